// File: rtl/wt_dcache_rd_arb.sv
// Read-port arbiter for the write-through L1 data cache.
// Shares the single tag/data array read port between NumPorts requesters
// (load unit, PTW, write buffer). Two priority classes with round-robin
// inside the winning class, yields to miss-unit line writes, and boosts the
// low class after StarveLimit consecutive losses. The granted port's ID and
// tag are registered into a one-stage compare pipeline.

// Per-port class split: which class a requesting port belongs to this cycle.
module wt_dcache_rd_arb_port (
    input  logic req,
    input  logic prio,
    output logic hi,
    output logic lo
);
    assign hi = req & prio;
    assign lo = req & ~prio;
endmodule

module wt_dcache_rd_arb #(
    parameter int unsigned NumPorts    = 3,
    parameter int unsigned StarveLimit = 8,
    parameter int unsigned TagWidth    = 28,
    parameter int unsigned IdxWidth    = 8,
    parameter int unsigned OffWidth    = 4,
    localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned CW = $clog2(StarveLimit + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumPorts-1:0]                rd_req_i,
    input  logic [NumPorts-1:0]                rd_prio_i,
    input  logic [NumPorts-1:0]                rd_tag_only_i,
    input  logic [NumPorts-1:0][TagWidth-1:0]  rd_tag_i,
    input  logic [NumPorts-1:0][IdxWidth-1:0]  rd_idx_i,
    input  logic [NumPorts-1:0][OffWidth-1:0]  rd_off_i,
    output logic [NumPorts-1:0]                rd_ack_o,
    input  logic                               wr_cl_vld_i,
    output logic                               mem_rd_req_o,
    output logic                               mem_rd_tag_only_o,
    output logic [IdxWidth-1:0]                mem_rd_idx_o,
    output logic [OffWidth-1:0]                mem_rd_off_o,
    output logic                               rsp_vld_o,
    output logic [PW-1:0]                      rsp_port_o,
    output logic [TagWidth-1:0]                rsp_tag_o,
    output logic                               rsp_tag_only_o
);

    localparam logic [PW:0]   NumPortsW = (PW+1)'(NumPorts);
    localparam logic [PW-1:0] LastRst   = PW'(NumPorts - 1);
    localparam logic [CW-1:0] CntMax    = CW'(StarveLimit);

    logic [NumPorts-1:0] hi_req, lo_req, cls;
    logic                hi_any, lo_any, boost, use_hi;
    logic [PW-1:0]       last_q, win;
    logic [PW:0]         cand;
    logic                found, gnt;
    logic [CW-1:0]       starve_cnt;

    wt_dcache_rd_arb_port u_port [NumPorts-1:0] (
        .req  (rd_req_i),
        .prio (rd_prio_i),
        .hi   (hi_req),
        .lo   (lo_req)
    );

    // A saturated starvation counter flips the winning class to low for one grant.
    assign hi_any = |hi_req;
    assign lo_any = |lo_req;
    assign boost  = (starve_cnt == CntMax) && lo_any;
    assign use_hi = hi_any && !boost;
    assign cls    = use_hi ? hi_req : lo_req;

    // Round-robin search upward from last_q+1, wrapping modulo NumPorts.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NumPorts; i++) begin
            cand = {1'b0, last_q} + (PW+1)'(i);
            if (cand >= NumPortsW) cand = cand - NumPortsW;
            if (!found && cls[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
    end

    // A miss-unit line write owns the array this cycle, so nobody is granted.
    assign gnt = found && !wr_cl_vld_i;

    for (genvar k = 0; k < NumPorts; k++) begin : g_ack
        assign rd_ack_o[k] = gnt && (win == PW'(k));
    end

    // Array-side mux; all fields read 0 when no port is granted.
    assign mem_rd_req_o      = gnt;
    assign mem_rd_tag_only_o = gnt ? rd_tag_only_i[win] : 1'b0;
    assign mem_rd_idx_o      = gnt ? rd_idx_i[win]      : '0;
    assign mem_rd_off_o      = gnt ? rd_off_i[win]      : '0;

    // Round-robin pointer moves only on a grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  last_q <= LastRst;
        else if (gnt) last_q <= win;
    end

    // Count consecutive high-class wins while the low class waits; frozen while the array is busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (!wr_cl_vld_i) begin
            if (!lo_any || (gnt && !use_hi)) starve_cnt <= '0;
            else if (starve_cnt != CntMax)   starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Response stage: valid pulses one cycle after a grant, payload holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_o      <= 1'b0;
            rsp_port_o     <= '0;
            rsp_tag_o      <= '0;
            rsp_tag_only_o <= 1'b0;
        end else begin
            rsp_vld_o <= gnt;
            if (gnt) begin
                rsp_port_o     <= win;
                rsp_tag_o      <= rd_tag_i[win];
                rsp_tag_only_o <= rd_tag_only_i[win];
            end
        end
    end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Bench for wt_dcache_rd_arb: directed scenarios plus a randomized run, all
// checked against a behavioural model of the arbitration rules.
module tb_wt_dcache_rd_arb;

    localparam int N     = 3;
    localparam int LIMIT = 4;
    localparam int TW    = 16;
    localparam int IW    = 6;
    localparam int OW    = 4;
    localparam int PW    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [N-1:0]         rd_req, rd_prio, rd_to, rd_ack;
    logic [N-1:0][TW-1:0] rd_tag;
    logic [N-1:0][IW-1:0] rd_idx;
    logic [N-1:0][OW-1:0] rd_off;
    logic                 wr_cl_vld;
    logic                 mem_rd_req, mem_rd_tag_only;
    logic [IW-1:0]        mem_rd_idx;
    logic [OW-1:0]        mem_rd_off;
    logic                 rsp_vld, rsp_tag_only;
    logic [PW-1:0]        rsp_port;
    logic [TW-1:0]        rsp_tag;

    wt_dcache_rd_arb #(
        .NumPorts(N), .StarveLimit(LIMIT), .TagWidth(TW), .IdxWidth(IW), .OffWidth(OW)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .rd_req_i          (rd_req),
        .rd_prio_i         (rd_prio),
        .rd_tag_only_i     (rd_to),
        .rd_tag_i          (rd_tag),
        .rd_idx_i          (rd_idx),
        .rd_off_i          (rd_off),
        .rd_ack_o          (rd_ack),
        .wr_cl_vld_i       (wr_cl_vld),
        .mem_rd_req_o      (mem_rd_req),
        .mem_rd_tag_only_o (mem_rd_tag_only),
        .mem_rd_idx_o      (mem_rd_idx),
        .mem_rd_off_o      (mem_rd_off),
        .rsp_vld_o         (rsp_vld),
        .rsp_port_o        (rsp_port),
        .rsp_tag_o         (rsp_tag),
        .rsp_tag_only_o    (rsp_tag_only)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    wire [N+1+IW+OW:0] comb_obs = {rd_ack, mem_rd_req, mem_rd_tag_only, mem_rd_idx, mem_rd_off};
    wire [PW+TW+1:0]   rsp_obs  = {rsp_vld, rsp_port, rsp_tag, rsp_tag_only};

    // Behavioural model state
    int             m_last, m_cnt, e_win;
    bit             e_lo_any;
    logic           m_rsp_vld, m_rsp_to;
    logic [PW-1:0]  m_rsp_port;
    logic [TW-1:0]  m_rsp_tag;
    logic [N+1+IW+OW:0] comb_exp;
    logic [PW+TW+1:0]   rsp_exp;

    task automatic model_reset();
        m_last = N - 1; m_cnt = 0;
        m_rsp_vld = 1'b0; m_rsp_port = '0; m_rsp_tag = '0; m_rsp_to = 1'b0;
    endtask

    // Winner = eligible port of the winning class nearest after the last grant.
    task automatic model_eval();
        bit hi_any = 0, boost;
        bit [N-1:0] cls;
        logic [N-1:0] e_ack;
        int best = N;
        int d;
        e_lo_any = 0;
        for (int k = 0; k < N; k++) begin
            if (rd_req[k] &&  rd_prio[k]) hi_any = 1;
            if (rd_req[k] && !rd_prio[k]) e_lo_any = 1;
        end
        boost = (m_cnt == LIMIT) && e_lo_any;
        for (int k = 0; k < N; k++)
            cls[k] = rd_req[k] && (rd_prio[k] == (hi_any && !boost));
        e_win = -1;
        if (!wr_cl_vld)
            for (int k = 0; k < N; k++)
                if (cls[k]) begin
                    d = (k - m_last - 1 + 2*N) % N;
                    if (d < best) begin best = d; e_win = k; end
                end
        e_ack = '0;
        if (e_win >= 0) begin
            e_ack[e_win] = 1'b1;
            comb_exp = {e_ack, 1'b1, rd_to[e_win], rd_idx[e_win], rd_off[e_win]};
        end else begin
            comb_exp = '0;
        end
        rsp_exp = {m_rsp_vld, m_rsp_port, m_rsp_tag, m_rsp_to};
    endtask

    task automatic model_clock();
        if (e_win >= 0) begin
            m_last = e_win; m_rsp_vld = 1'b1; m_rsp_port = e_win[PW-1:0];
            m_rsp_tag = rd_tag[e_win]; m_rsp_to = rd_to[e_win];
        end else begin
            m_rsp_vld = 1'b0;
        end
        if (!wr_cl_vld) begin
            if (!e_lo_any)                             m_cnt = 0;
            else if (e_win >= 0 && !rd_prio[e_win])    m_cnt = 0;
            else if (m_cnt < LIMIT)                    m_cnt++;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic rand_payload();
        for (int k = 0; k < N; k++) begin
            rd_tag[k] = TW'($urandom);
            rd_idx[k] = IW'($urandom);
            rd_off[k] = OW'($urandom);
            rd_to[k]  = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rd_req = '0; rd_prio = '0; wr_cl_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rd_req = '0; rd_prio = '0; wr_cl_vld = 1'b0; rand_payload();
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (rsp_obs !== '0) begin n_err++; $display("FAIL reset_rsp got %h want 0", rsp_obs); end
        n_vec++; if (comb_obs !== '0) begin n_err++; $display("FAIL reset_comb got %h want 0", comb_obs); end
        n_vec++; if (dut.starve_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", dut.starve_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        model_eval();
        @(negedge clk);
        n_vec++; if (comb_obs !== comb_exp) begin n_err++; $display("FAIL reset_idle_comb got %h want %h", comb_obs, comb_exp); end
        adv();
    endtask

    task automatic test_first_grant();
        rand_payload();
        rd_req = 3'b011; rd_prio = 3'b011;
        model_eval();
        @(negedge clk);
        n_vec++; if (rd_ack !== 3'b001) begin n_err++; $display("FAIL first_ack got %b want 001", rd_ack); end
        n_vec++; if (mem_rd_idx !== rd_idx[0]) begin n_err++; $display("FAIL first_idx got %h want %h", mem_rd_idx, rd_idx[0]); end
        n_vec++; if (comb_obs !== comb_exp) begin n_err++; $display("FAIL first_comb got %h want %h", comb_obs, comb_exp); end
        adv();
        rd_req = '0;
        model_eval();
        @(negedge clk);
        n_vec++; if ({rsp_vld, rsp_port} !== {1'b1, 2'd0}) begin n_err++; $display("FAIL first_rsp got vld=%b port=%0d want vld=1 port=0", rsp_vld, rsp_port); end
        n_vec++; if (rsp_tag !== rd_tag[0]) begin n_err++; $display("FAIL first_tag got %h want %h", rsp_tag, rd_tag[0]); end
        adv();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        rd_req = 3'b011; rd_prio = 3'b011;
        for (int c = 0; c < 6; c++) begin
            rand_payload();
            want = (c % 2 == 0) ? 3'b001 : 3'b010;
            model_eval();
            @(negedge clk);
            n_vec++; if (rd_ack !== want) begin n_err++; $display("FAIL rr_ack cyc %0d got %b want %b", c, rd_ack, want); end
            n_vec++; if (comb_obs !== comb_exp) begin n_err++; $display("FAIL rr_comb cyc %0d got %h want %h", c, comb_obs, comb_exp); end
            adv();
        end
    endtask

    task automatic test_array_busy();
        do_reset();
        rand_payload();
        rd_req = 3'b111; rd_prio = 3'b011;
        model_eval(); @(negedge clk);
        n_vec++; if (rd_ack !== 3'b001) begin n_err++; $display("FAIL busy_pre_ack got %b want 001", rd_ack); end
        adv();
        wr_cl_vld = 1'b1;
        model_eval(); @(negedge clk);
        n_vec++; if ({rd_ack, mem_rd_req} !== 4'b0) begin n_err++; $display("FAIL busy_ack got ack=%b req=%b want 0", rd_ack, mem_rd_req); end
        n_vec++; if (comb_obs !== comb_exp) begin n_err++; $display("FAIL busy_comb got %h want %h", comb_obs, comb_exp); end
        adv();
        wr_cl_vld = 1'b0; rd_req = '0;
        model_eval(); @(negedge clk);
        n_vec++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL busy_rsp_vld got %b want 0", rsp_vld); end
        n_vec++; if (dut.starve_cnt !== 3'd1) begin n_err++; $display("FAIL busy_cnt got %0d want 1", dut.starve_cnt); end
        adv();
    endtask

    task automatic test_starve_boost();
        logic [N-1:0] want;
        int p;
        do_reset();
        rd_req = 3'b111; rd_prio = 3'b011;
        for (int c = 0; c < 19; c++) begin
            rand_payload();
            p = (c % 5 == 4) ? 2 : (c % 5) % 2;
            want = '0; want[p] = 1'b1;
            model_eval(); @(negedge clk);
            n_vec++; if (rd_ack !== want) begin n_err++; $display("FAIL boost_ack cyc %0d got %b want %b", c, rd_ack, want); end
            n_vec++; if (dut.starve_cnt !== 3'(m_cnt)) begin n_err++; $display("FAIL boost_cnt cyc %0d got %0d want %0d", c, dut.starve_cnt, m_cnt); end
            adv();
        end
        // counter is saturated now; a busy array defers the boost
        wr_cl_vld = 1'b1;
        model_eval(); @(negedge clk);
        n_vec++; if (rd_ack !== 3'b000) begin n_err++; $display("FAIL boost_busy_ack got %b want 000", rd_ack); end
        adv();
        n_vec++; if (dut.starve_cnt !== 3'd4) begin n_err++; $display("FAIL boost_busy_cnt got %0d want 4", dut.starve_cnt); end
        wr_cl_vld = 1'b0;
        model_eval(); @(negedge clk);
        n_vec++; if (rd_ack !== 3'b100) begin n_err++; $display("FAIL boost_pending_ack got %b want 100", rd_ack); end
        adv();
        n_vec++; if (dut.starve_cnt !== 3'd0) begin n_err++; $display("FAIL boost_clear_cnt got %0d want 0", dut.starve_cnt); end
    endtask

    task automatic test_payload();
        rand_payload();
        rd_req = 3'b010; rd_prio = 3'($urandom); wr_cl_vld = 1'b0;
        rd_tag[1] = 16'h1A2B; rd_to[1] = 1'b1;
        model_eval(); @(negedge clk);
        n_vec++; if (rd_ack !== 3'b010) begin n_err++; $display("FAIL payload_ack got %b want 010", rd_ack); end
        adv();
        rd_req = '0; rd_tag[1] = 16'h5555; rd_to[1] = 1'b0;
        model_eval(); @(negedge clk);
        n_vec++; if (rsp_obs !== {1'b1, 2'd1, 16'h1A2B, 1'b1}) begin n_err++; $display("FAIL payload_rsp got %h want %h", rsp_obs, {1'b1, 2'd1, 16'h1A2B, 1'b1}); end
        adv();
        model_eval(); @(negedge clk);
        n_vec++; if (rsp_obs !== {1'b0, 2'd1, 16'h1A2B, 1'b1}) begin n_err++; $display("FAIL payload_hold got %h want %h", rsp_obs, {1'b0, 2'd1, 16'h1A2B, 1'b1}); end
        n_vec++; if (rsp_obs !== rsp_exp) begin n_err++; $display("FAIL payload_model got %h want %h", rsp_obs, rsp_exp); end
        adv();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd_req = 3'b111; rd_prio = 3'b011;
        for (int c = 0; c < 3; c++) begin
            rand_payload(); model_eval(); adv();
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (rsp_obs !== '0) begin n_err++; $display("FAIL midrst_rsp got %h want 0", rsp_obs); end
        n_vec++; if (dut.starve_cnt !== 3'd0) begin n_err++; $display("FAIL midrst_cnt got %0d want 0", dut.starve_cnt); end
        #4 rst_n = 1'b1;
        model_reset();
        model_eval();
        #1;
        n_vec++; if (rd_ack !== 3'b001) begin n_err++; $display("FAIL midrst_ack got %b want 001", rd_ack); end
        adv();
        rd_req = '0;
        model_eval(); @(negedge clk);
        n_vec++; if ({rsp_vld, rsp_port} !== {1'b1, 2'd0}) begin n_err++; $display("FAIL midrst_rsp_after got vld=%b port=%0d want vld=1 port=0", rsp_vld, rsp_port); end
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_payload();
            if (c % 16 == 0) rd_prio = 3'($urandom);
            rd_req    = 3'($urandom);
            wr_cl_vld = ($urandom_range(0, 3) == 0);
            model_eval(); @(negedge clk);
            n_vec++; if (comb_obs !== comb_exp) begin n_err++; $display("FAIL rand_comb cyc %0d got %h want %h", c, comb_obs, comb_exp); end
            n_vec++; if (rsp_obs !== rsp_exp) begin n_err++; $display("FAIL rand_rsp cyc %0d got %h want %h", c, rsp_obs, rsp_exp); end
            n_vec++; if (dut.starve_cnt !== 3'(m_cnt)) begin n_err++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", c, dut.starve_cnt, m_cnt); end
            adv();
        end
        wr_cl_vld = 1'b0; rd_req = '0;
    endtask

    initial begin
        rd_req = '0; rd_prio = '0; rd_to = '0; wr_cl_vld = 1'b0;
        rd_tag = '0; rd_idx = '0; rd_off = '0;
        model_reset();
        test_reset();
        test_first_grant();
        test_round_robin();
        test_array_busy();
        test_starve_boost();
        test_payload();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wt_dcache_rd_arb.md
# wt_dcache_rd_arb

Read-port arbiter for the write-through L1 data cache. It shares the single tag/data array read port between `NumPorts` requesters: the load unit, the PTW and the write buffer. It resolves priority classes with round-robin inside each class, yields to miss-unit cache-line writes, and stops the low-priority write-buffer port from starving. It also registers the granted port's ID and tag into a one-stage compare pipeline.

## Interface

Parameters:
- `NumPorts`, 3: number of read requesters; must be ≥ 2.
- `StarveLimit`, 8: number of consecutive lost arbitrations a low-priority requester tolerates before it is boosted; must be ≥ 1.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `rd_req_i` in `NumPorts`: per-port read request, level, held until acked.
- `rd_prio_i` in `NumPorts`: 1 means high-priority class, 0 means low.
- `rd_tag_only_i` in `NumPorts`: per-port flag for a tag-only read.
- `rd_tag_i` in `NumPorts`×`DCACHE_TAG_WIDTH`: per-port tag for the next-cycle compare.
- `rd_idx_i` in `NumPorts`×`DCACHE_CL_IDX_WIDTH`: per-port set index.
- `rd_off_i` in `NumPorts`×`DCACHE_OFFSET_WIDTH`: per-port byte offset.
- `rd_ack_o` out `NumPorts`: one-hot grant, combinational, same cycle as the request.
- `wr_cl_vld_i` in 1: the miss unit is writing or invalidating a cache line this cycle, so the array is busy.
- `mem_rd_req_o` out 1: array read enable.
- `mem_rd_tag_only_o` out 1: muxed tag-only flag.
- `mem_rd_idx_o` out `DCACHE_CL_IDX_WIDTH`: muxed index.
- `mem_rd_off_o` out `DCACHE_OFFSET_WIDTH`: muxed offset.
- `rsp_vld_o` out 1: registered; a grant occurred in the previous cycle.
- `rsp_port_o` out `PW`=max(1,$clog2(`NumPorts`)): registered ID of the granted port.
- `rsp_tag_o` out `DCACHE_TAG_WIDTH`: registered tag of the granted port.
- `rsp_tag_only_o` out 1: registered tag-only flag of the granted port.

## Operation

**Eligibility**
- A port is eligible when `rd_req_i[k]` is 1.
- No port is granted in any cycle where `wr_cl_vld_i` is 1. In that cycle `rd_ack_o` is 0 and `mem_rd_req_o` is 0.

**Class selection**
- The high class is the set of eligible ports with `rd_prio_i` = 1. The low class is the rest.
- The winning class is the high class if it is non-empty, unless `boost` is set. Otherwise it is the low class.
- `boost` is set when `starve_cnt` == `StarveLimit` and the low class is non-empty.

**Round-robin**
- A single pointer `last_q` holds the most recently granted port ID.
- The winner is the first port of the winning class found by searching upward from `last_q`+1, modulo `NumPorts`.
- `last_q` updates only on a grant.

**Starvation counter**
- `starve_cnt` is `$clog2(StarveLimit+1)` bits wide.
- It increments when the low class is non-empty, `wr_cl_vld_i` is 0, and the grant goes to the high class.
- It saturates at `StarveLimit`.
- It clears on any low-class grant.
- It clears in any cycle where the low class is empty.
- It holds when `wr_cl_vld_i` is 1.

**Array-side mux**
- `mem_rd_req_o` = |`rd_ack_o`.
- `mem_rd_idx_o`, `mem_rd_off_o` and `mem_rd_tag_only_o` select the winner's fields.
- When there is no grant, these outputs are 0.

**Response stage**
- On a grant, the next cycle has `rsp_vld_o` = 1, with `rsp_port_o`, `rsp_tag_o` and `rsp_tag_only_o` from the granted port.
- Without a grant, `rsp_vld_o` = 0 and the other `rsp_*` outputs hold their values.

**Change of request**
- A requester that drops `rd_req_i` without an ack loses nothing: no state depends on a pending request except `starve_cnt`.

## Timing

- Ack latency is 0 cycles: `rd_ack_o` is combinational from `rd_req_i`, `rd_prio_i`, `wr_cl_vld_i` and the registered state.
- Response latency is exactly 1 cycle after the ack.
- Throughput is one grant per cycle.
- Reset values:
  - `last_q` = `NumPorts`-1, so port 0 wins first.
  - `starve_cnt` = 0.
  - `rsp_vld_o` = 0, `rsp_port_o` = 0, `rsp_tag_o` = 0, `rsp_tag_only_o` = 0.
  - Combinational outputs are 0 while `rd_req_i` = 0.
- Reset asserted mid-operation clears all registers immediately and asynchronously. A grant issued in the cycle reset asserts produces no `rsp_vld_o`.
- Simultaneous events in one cycle:
  - A grant and a `starve_cnt` clear happen together.
  - A saturated counter with `boost` grants the low class that cycle, and the counter clears next cycle.
  - `wr_cl_vld_i` overrides `boost`. The boost stays pending.
- Wrap-around: a search from `last_q` = `NumPorts`-1 starts at port 0.

## Test plan

1. **Reset and first grant.** After reset, set `rd_req_i`=3'b011 and `rd_prio_i`=3'b011 → `rd_ack_o`=3'b001 and `mem_rd_idx_o` = port 0 index. Next cycle `rsp_vld_o`=1 and `rsp_port_o`=0.
2. **Round-robin.** Hold ports 0 and 1 high-priority and requesting for 6 cycles → acks go 0,1,0,1,0,1.
3. **Array busy.** Set `wr_cl_vld_i`=1 with `rd_req_i`=3'b111 → `rd_ack_o`=0 and `mem_rd_req_o`=0, next cycle `rsp_vld_o`=0, and `starve_cnt` is unchanged.
4. **Starvation boost.** With `StarveLimit`=4, hold ports 0 and 1 high-priority and port 2 low-priority, all requesting → port 2 is acked on the 5th cycle. The pattern then repeats with 4 high-class grants between each port-2 grant.
5. **Response payload.** Grant port 1 with tag 0x1A2B and tag-only=1 → next cycle `rsp_vld_o`=1, `rsp_port_o`=1, `rsp_tag_o`=0x1A2B, `rsp_tag_only_o`=1. The following idle cycle has `rsp_vld_o`=0 with the tag held.
6. **Reset mid-run.** Pulse `rst_ni` low for half a cycle during test 4 → all `rsp_*` outputs and `starve_cnt` go to 0 immediately, and after release port 0 wins first.
